// File: rtl/branch_resolver_pkg.sv
// Shared types for the fetch-stage predictor and the EX-stage branch resolver.
// Holds the register width, resolver state encodings and branch prediction record.
package branch_resolver_pkg;

  localparam int REG_WIDTH = 32;

  typedef logic bool_t;
  localparam bool_t TRUE  = 1'b1;
  localparam bool_t FALSE = 1'b0;

  typedef logic [1:0] resolver_state_t;
  localparam resolver_state_t ST_IDLE     = 2'd0;
  localparam resolver_state_t ST_WAIT_DS  = 2'd1;
  localparam resolver_state_t ST_REDIRECT = 2'd2;

  typedef struct packed {
    logic                 taken;
    logic [REG_WIDTH-1:0] target;
  } branch_pred_t;

  // A direction mismatch always mispredicts; a target mismatch only matters when both say taken.
  function automatic bool_t is_mispredict(input branch_pred_t pred, input branch_pred_t actual);
    return (pred.taken != actual.taken) ||
           (pred.taken && actual.taken && (pred.target != actual.target));
  endfunction

  function automatic logic [REG_WIDTH-1:0] correct_pc(input branch_pred_t actual,
                                                      input logic [REG_WIDTH-1:0] pc);
    return actual.taken ? actual.target : pc + REG_WIDTH'(8);
  endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// EX-stage branch information in, redirect handshake and stall/flush controls out.
interface branch_resolver_if;
  import branch_resolver_pkg::*;

  logic                 ex_valid;
  logic                 ex_stall;
  logic                 ex_kill;
  logic                 ex_is_branch;
  logic                 ex_pred_taken;
  logic [REG_WIDTH-1:0] ex_pred_target;
  logic [REG_WIDTH-1:0] ex_pc;
  logic                 ex_actual_taken;
  logic [REG_WIDTH-1:0] ex_actual_target;
  logic                 redirect_valid;
  logic                 redirect_ready;
  logic [REG_WIDTH-1:0] redirect_pc;
  logic                 flush_front;
  logic                 busy;

  modport master (
    output ex_valid, ex_stall, ex_kill, ex_is_branch, ex_pred_taken, ex_pred_target,
           ex_pc, ex_actual_taken, ex_actual_target, redirect_ready,
    input  redirect_valid, redirect_pc, flush_front, busy
  );

  modport slave (
    input  ex_valid, ex_stall, ex_kill, ex_is_branch, ex_pred_taken, ex_pred_target,
           ex_pc, ex_actual_taken, ex_actual_target, redirect_ready,
    output redirect_valid, redirect_pc, flush_front, busy
  );

endinterface

// File: rtl/branch_resolver_sat_counter.sv
// Statistics counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// EX-stage branch resolver: checks the carried prediction against the resolved outcome
// and, on a mispredict, redirects fetch once the delay slot has been accepted.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int DS_ENABLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  branch_resolver_if.slave bus,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispredicts
);

  localparam bool_t DS_ON = (DS_ENABLE != 0) ? TRUE : FALSE;

  resolver_state_t      state;
  resolver_state_t      state_nxt;
  logic [REG_WIDTH-1:0] redirect_pc_q;
  branch_pred_t         pred;
  branch_pred_t         actual;
  logic                 accept;
  logic                 resolve;
  logic                 mispredict;

  assign pred       = '{taken: bus.ex_pred_taken,   target: bus.ex_pred_target};
  assign actual     = '{taken: bus.ex_actual_taken, target: bus.ex_actual_target};
  assign accept     = bus.ex_valid && !bus.ex_stall && !bus.ex_kill;
  // Only branches seen in IDLE are resolved; one sitting in a delay slot is ignored.
  assign resolve    = (state == ST_IDLE) && accept && bus.ex_is_branch;
  assign mispredict = is_mispredict(pred, actual);

  always_comb begin
    state_nxt = state;
    if (bus.ex_kill) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (resolve && mispredict) begin
            state_nxt = (DS_ON == FALSE) ? ST_REDIRECT : ST_WAIT_DS;
          end
        end
        ST_WAIT_DS: begin
          if (accept) begin
            state_nxt = ST_REDIRECT;
          end
        end
        ST_REDIRECT: begin
          if (bus.redirect_ready) begin
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      redirect_pc_q <= '0;
    end else begin
      state <= state_nxt;
      if (resolve && mispredict) begin
        redirect_pc_q <= correct_pc(actual, bus.ex_pc);
      end
    end
  end

  // Handshake and pipeline controls decode the state register only, so they never see inputs combinationally.
  assign bus.redirect_valid = (state == ST_REDIRECT);
  assign bus.flush_front    = (state == ST_REDIRECT);
  assign bus.busy           = (state == ST_REDIRECT);
  assign bus.redirect_pc    = redirect_pc_q;

  sat_counter #(.WIDTH(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (resolve),
    .clr   (1'b0),
    .count (stat_branches)
  );

  sat_counter #(.WIDTH(CNT_W)) u_mispredict_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (resolve && mispredict),
    .clr   (1'b0),
    .count (stat_mispredicts)
  );

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: one delay-slot instance and one immediate-redirect instance
// with 2-bit counters, driven identically and compared against a behavioural model.
module tb_branch_resolver;
  import branch_resolver_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_stall, ex_kill, ex_is_branch, ex_pred_taken, ex_actual_taken;
  logic        redirect_ready;
  logic [31:0] ex_pred_target, ex_pc, ex_actual_target;
  logic [31:0] stat_br_a, stat_mis_a;
  logic [1:0]  stat_br_b, stat_mis_b;

  int checks = 0;
  int errors = 0;

  // Model: per instance, whether a delay slot is owed, whether a redirect is outstanding,
  // the PC fetch should resume at, and the counts.
  bit              m_owe_ds [2];
  bit              m_out    [2];
  logic [31:0]     m_pc     [2];
  longint unsigned m_br     [2];
  longint unsigned m_mis    [2];
  bit              m_ds     [2] = '{1'b1, 1'b0};
  longint unsigned m_max    [2] = '{64'hFFFF_FFFF, 64'd3};

  always #5 clk = ~clk;

  branch_resolver_if bus_a();
  branch_resolver_if bus_b();

  assign bus_a.ex_valid = ex_valid;          assign bus_b.ex_valid = ex_valid;
  assign bus_a.ex_stall = ex_stall;          assign bus_b.ex_stall = ex_stall;
  assign bus_a.ex_kill = ex_kill;            assign bus_b.ex_kill = ex_kill;
  assign bus_a.ex_is_branch = ex_is_branch;  assign bus_b.ex_is_branch = ex_is_branch;
  assign bus_a.ex_pred_taken = ex_pred_taken;     assign bus_b.ex_pred_taken = ex_pred_taken;
  assign bus_a.ex_pred_target = ex_pred_target;   assign bus_b.ex_pred_target = ex_pred_target;
  assign bus_a.ex_pc = ex_pc;                assign bus_b.ex_pc = ex_pc;
  assign bus_a.ex_actual_taken = ex_actual_taken;   assign bus_b.ex_actual_taken = ex_actual_taken;
  assign bus_a.ex_actual_target = ex_actual_target; assign bus_b.ex_actual_target = ex_actual_target;
  assign bus_a.redirect_ready = redirect_ready;     assign bus_b.redirect_ready = redirect_ready;

  branch_resolver #(.CNT_W(32), .DS_ENABLE(1)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave),
    .stat_branches(stat_br_a), .stat_mispredicts(stat_mis_a)
  );

  branch_resolver #(.CNT_W(2), .DS_ENABLE(0)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave),
    .stat_branches(stat_br_b), .stat_mispredicts(stat_mis_b)
  );

  task automatic checkOne(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkOne({tag, "_a_valid"}, 64'(bus_a.redirect_valid), 64'(m_out[0]));
    checkOne({tag, "_a_flush"}, 64'(bus_a.flush_front),    64'(m_out[0]));
    checkOne({tag, "_a_busy"},  64'(bus_a.busy),           64'(m_out[0]));
    checkOne({tag, "_a_pc"},    64'(bus_a.redirect_pc),    64'(m_pc[0]));
    checkOne({tag, "_a_br"},    64'(stat_br_a),            m_br[0]);
    checkOne({tag, "_a_mis"},   64'(stat_mis_a),           m_mis[0]);
    checkOne({tag, "_b_valid"}, 64'(bus_b.redirect_valid), 64'(m_out[1]));
    checkOne({tag, "_b_flush"}, 64'(bus_b.flush_front),    64'(m_out[1]));
    checkOne({tag, "_b_busy"},  64'(bus_b.busy),           64'(m_out[1]));
    checkOne({tag, "_b_pc"},    64'(bus_b.redirect_pc),    64'(m_pc[1]));
    checkOne({tag, "_b_br"},    64'(stat_br_b),            m_br[1]);
    checkOne({tag, "_b_mis"},   64'(stat_mis_b),           m_mis[1]);
  endtask

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      m_owe_ds[i] = 1'b0; m_out[i] = 1'b0; m_pc[i] = '0; m_br[i] = 0; m_mis[i] = 0;
    end
  endtask

  task automatic modelStep();
    bit          acc;
    bit          wrong;
    logic [63:0] resume;
    acc    = ex_valid && !ex_stall && !ex_kill;
    wrong  = (ex_pred_taken != ex_actual_taken) ||
             (ex_pred_taken && ex_actual_taken && (ex_pred_target != ex_actual_target));
    resume = ex_actual_taken ? 64'(ex_actual_target) : (64'(ex_pc) + 64'd8) % 64'h1_0000_0000;
    for (int i = 0; i < 2; i++) begin
      if (ex_kill) begin
        m_owe_ds[i] = 1'b0;
        m_out[i]    = 1'b0;
      end else if (m_out[i]) begin
        if (redirect_ready) m_out[i] = 1'b0;
      end else if (m_owe_ds[i]) begin
        if (acc) begin
          m_owe_ds[i] = 1'b0;
          m_out[i]    = 1'b1;
        end
      end else if (acc && ex_is_branch) begin
        if (m_br[i] < m_max[i]) m_br[i]++;
        if (wrong) begin
          if (m_mis[i] < m_max[i]) m_mis[i]++;
          m_pc[i] = resume[31:0];
          if (m_ds[i]) m_owe_ds[i] = 1'b1;
          else         m_out[i]    = 1'b1;
        end
      end
    end
  endtask

  task automatic applyStimulus(input string tag, input logic v, input logic br,
                               input logic pt, input logic at, input logic [31:0] pc,
                               input logic [31:0] ptgt, input logic [31:0] atgt,
                               input logic rdy, input logic stall, input logic kill);
    ex_valid = v; ex_is_branch = br; ex_pred_taken = pt; ex_actual_taken = at;
    ex_pc = pc; ex_pred_target = ptgt; ex_actual_target = atgt;
    redirect_ready = rdy; ex_stall = stall; ex_kill = kill;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput(tag);
  endtask

  task automatic brStep(input string tag, input logic pt, input logic at, input logic [31:0] pc,
                        input logic [31:0] ptgt, input logic [31:0] atgt, input logic rdy);
    applyStimulus(tag, 1'b1, 1'b1, pt, at, pc, ptgt, atgt, rdy, 1'b0, 1'b0);
  endtask

  task automatic dsStep(input string tag, input logic rdy);
    applyStimulus(tag, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0104, '0, '0, rdy, 1'b0, 1'b0);
  endtask

  task automatic idleStep(input string tag, input logic rdy);
    applyStimulus(tag, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, rdy, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    ex_valid = 0; ex_stall = 0; ex_kill = 0; ex_is_branch = 0; ex_pred_taken = 0;
    ex_actual_taken = 0; redirect_ready = 0;
    ex_pc = '0; ex_pred_target = '0; ex_actual_target = '0;
    modelReset();
    #12;
    checkOutput("reset");
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] correct not-taken");
    brStep("t1_br", 1'b0, 1'b0, 32'h8000_0100, 32'h0, 32'h8000_0200, 1'b0);
    idleStep("t1_idle", 1'b0);
    checkOne("t1_branches", 64'(stat_br_a), 64'd1);
    checkOne("t1_no_redirect", 64'(bus_a.redirect_valid), 64'd0);

    $display("[TB] forward branch taken, predicted not-taken");
    brStep("t2_br", 1'b0, 1'b1, 32'h8000_0100, 32'h0, 32'h8000_0200, 1'b0);
    checkOne("t2_b_immediate", 64'(bus_b.redirect_valid), 64'd1);
    idleStep("t2_gap", 1'b0);
    checkOne("t2_a_wait_busy", 64'(bus_a.busy), 64'd0);
    dsStep("t2_ds", 1'b0);
    checkOne("t2_a_valid", 64'(bus_a.redirect_valid), 64'd1);
    checkOne("t2_a_pc", 64'(bus_a.redirect_pc), 64'h8000_0200);
    checkOne("t2_a_mis", 64'(stat_mis_a), 64'd1);
    idleStep("t2_hold", 1'b0);
    idleStep("t2_ready", 1'b1);
    checkOne("t2_a_released", 64'(bus_a.busy), 64'd0);
    idleStep("t2_after", 1'b0);

    $display("[TB] backward branch not taken, ready held off");
    brStep("t3_br", 1'b1, 1'b0, 32'h8000_0040, 32'h8000_0000, 32'h0, 1'b0);
    dsStep("t3_ds", 1'b0);
    for (int k = 0; k < 3; k++) begin
      idleStep("t3_hold", 1'b0);
      checkOne("t3_pc_stable", 64'(bus_a.redirect_pc), 64'h8000_0048);
      checkOne("t3_flush_stable", 64'(bus_a.flush_front), 64'd1);
    end
    idleStep("t3_ready", 1'b1);
    checkOne("t3_idle_after_ready", 64'(bus_a.redirect_valid), 64'd0);
    idleStep("t3_after", 1'b0);

    $display("[TB] register jump and PC wraparound");
    brStep("t4_jr", 1'b0, 1'b1, 32'h8000_0300, 32'h8000_0000, 32'h8000_ABC0, 1'b0);
    dsStep("t4_jr_ds", 1'b0);
    checkOne("t4_jr_pc", 64'(bus_a.redirect_pc), 64'h8000_ABC0);
    idleStep("t4_jr_ready", 1'b1);
    idleStep("t4_gap", 1'b0);
    brStep("t4_wrap", 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h8000_0000, 32'h0, 1'b0);
    dsStep("t4_wrap_ds", 1'b0);
    checkOne("t4_wrap_pc", 64'(bus_a.redirect_pc), 64'h0000_0004);
    idleStep("t4_wrap_ready", 1'b1);
    idleStep("t4_after", 1'b0);

    $display("[TB] kill and asynchronous reset");
    brStep("t5_br1", 1'b0, 1'b1, 32'h8000_0500, 32'h0, 32'h8000_0600, 1'b0);
    applyStimulus("t5_kill_ds", 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0504, '0, '0, 1'b0, 1'b0, 1'b1);
    checkOne("t5_kill_ds_valid", 64'(bus_a.redirect_valid), 64'd0);
    idleStep("t5_gap", 1'b0);
    checkOne("t5_kill_ds_stays", 64'(bus_a.redirect_valid), 64'd0);
    brStep("t5_br2", 1'b0, 1'b1, 32'h8000_0700, 32'h0, 32'h8000_0800, 1'b0);
    dsStep("t5_ds2", 1'b0);
    applyStimulus("t5_kill_redir", 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    checkOne("t5_kill_redir_valid", 64'(bus_a.redirect_valid), 64'd0);
    brStep("t5_br3", 1'b0, 1'b1, 32'h8000_0900, 32'h0, 32'h8000_0A00, 1'b0);
    dsStep("t5_ds3", 1'b0);
    #2;
    rst = 1'b1;
    modelReset();
    #1;
    checkOutput("t5_async_rst");
    checkOne("t5_rst_valid", 64'(bus_a.redirect_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] back-to-back mispredicts and counter saturation");
    for (int k = 0; k < 5; k++) begin
      brStep("t6_br", 1'b1, 1'b0, 32'h8000_1000 + 32'(k * 16), 32'h8000_2000, 32'h0, 1'b0);
      checkOne("t6_b_next_cycle", 64'(bus_b.redirect_valid), 64'd1);
      idleStep("t6_ready", 1'b1);
    end
    checkOne("t6_b_mis_sat", 64'(stat_mis_b), 64'd3);
    checkOne("t6_b_br_sat", 64'(stat_br_b), 64'd3);

    $display("[TB] randomized traffic");
    for (int k = 0; k < 400; k++) begin
      applyStimulus("rnd",
                    1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)),
                    32'h8000_0000 + 32'($urandom_range(0, 255) * 4),
                    32'h8000_0000 + 32'($urandom_range(0, 3) * 4),
                    32'h8000_0000 + 32'($urandom_range(0, 3) * 4),
                    1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 15) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Execute-stage counterpart of the fetch-stage static branch predictor.
- Compares each branch's prediction, which travels down the pipe, against the outcome computed in EX. On a mispredict it waits for the MIPS delay slot to enter EX, then issues a registered redirect to fetch with a valid/ready handshake. While the redirect is pending it flushes the front end and stalls EX.
- Keeps saturating branch and mispredict counters for performance analysis.

Parameters:
CNT_W, 32, width of the statistics counters.
DS_ENABLE, 1, 1 = honour the branch delay slot before redirecting; 0 = redirect immediately.

Ports:
clk  input  1  core clock
rst  input  1  reset, asynchronous, active-high
ex_valid  input  1  instruction in EX is valid
ex_stall  input  1  EX is held this cycle; the instruction is not accepted
ex_kill  input  1  exception/eret flush of the whole pipe
ex_is_branch  input  1  instruction was flagged is_branch by the predictor
ex_pred_taken  input  1  predicted direction carried from fetch
ex_pred_target  input  REG_WIDTH  predicted target carried from fetch
ex_pc  input  REG_WIDTH  PC of the instruction in EX
ex_actual_taken  input  1  resolved direction
ex_actual_target  input  REG_WIDTH  resolved target; for JR/JALR this is the register value
redirect_valid  output  1  redirect request to fetch
redirect_ready  input  1  fetch accepts the redirect
redirect_pc  output  REG_WIDTH  corrected fetch PC
flush_front  output  1  flush IF/ID wrong-path instructions
busy  output  1  stall EX from accepting new instructions
stat_branches  output  CNT_W  resolved branch count
stat_mispredicts  output  CNT_W  mispredict count

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: state=IDLE; redirect_valid=0; redirect_pc=0; flush_front=0; busy=0; both counters=0.
- Accept: "accept" means ex_valid & !ex_stall & !ex_kill.
- Mispredict condition:
  - ex_pred_taken != ex_actual_taken, or
  - both taken and ex_pred_target != ex_actual_target.
- Correct PC:
  - ex_actual_taken ? ex_actual_target : ex_pc+8.
  - Arithmetic is 32-bit modulo; 0xFFFFFFFC+8 = 0x00000004.
- States:
  - IDLE, on accepted branch:
    - Increment stat_branches.
    - If mispredicted: latch correct PC into redirect_pc and increment stat_mispredicts.
    - Next state is WAIT_DS if DS_ENABLE=1, else REDIRECT.
    - A correctly predicted branch stays in IDLE.
  - WAIT_DS:
    - busy=0 so the delay slot can enter EX.
    - On the next accept (the delay slot), go to REDIRECT.
    - A branch in the delay slot is architecturally undefined: it is neither resolved nor counted.
  - REDIRECT:
    - redirect_valid=1, flush_front=1, busy=1.
    - redirect_pc is held stable until redirect_valid & redirect_ready, then go to IDLE. On that cycle all three outputs drop the following cycle.
- Outputs: redirect_valid, flush_front and busy are registered state decodes with no combinational path from inputs.
- Latency:
  - Mispredict accepted in cycle N.
  - DS_ENABLE=1: delay slot accepted in cycle M>N; redirect_valid is high from M+1.
  - DS_ENABLE=0: redirect_valid is high from N+1.
- Kill: ex_kill in any state forces IDLE next cycle and drops any pending redirect. Exception redirect has priority. Counters are not rolled back.
- Stall in WAIT_DS: ex_stall keeps WAIT_DS indefinitely.
- Ready timing: redirect_ready high before redirect_valid has no effect. redirect_ready low holds REDIRECT with no timeout.
- Counters: saturate at all-ones and do not wrap.
- Reset mid-operation: immediate return to reset values, including the counters.

Decomposition:
- Shared package (defines.svh): REG_WIDTH, bool/`true/`false, and a resolver_state_t enum {IDLE, WAIT_DS, REDIRECT}. The predictor and resolver share a branch_pred_t struct {taken, target}.
- One sub-module: sat_counter (parameter width; inputs inc, clr; output count). It is instantiated twice.

Test Plan:
1. Correct not-taken: pc=0x80000100, pred_taken=0, actual_taken=0 -> stays IDLE, no redirect; stat_branches=1, stat_mispredicts=0.
2. Forward branch predicted not-taken but taken: pc=0x80000100, actual_target=0x80000200, delay slot accepted 2 cycles later -> redirect_valid the cycle after the delay slot; redirect_pc=0x80000200; busy=1 until ready; mispredicts=1.
3. Backward branch predicted taken, actually not taken: pc=0x80000040 -> redirect_pc=0x80000048. Hold redirect_ready=0 for 3 cycles -> redirect_valid, redirect_pc and flush_front stay stable; IDLE the cycle after ready.
4. JR predicted not-taken with target 0x80000000, actual taken to 0x8000ABC0 -> redirect_pc=0x8000ABC0. Also check pc=0xFFFFFFFC not-taken mispredict -> redirect_pc=0x00000004.
5. ex_kill asserted in WAIT_DS and again in REDIRECT -> IDLE next cycle, redirect_valid never/no longer asserted. Async rst pulse mid-REDIRECT -> all outputs 0 immediately.
6. DS_ENABLE=0 with CNT_W=2: five consecutive mispredicts -> redirect_valid at N+1 each time; stat_mispredicts saturates at 3.
